// File: rtl/arm_alu_pkg.sv
// Shared types and constants for the multi-cycle execute-stage ALU.
//   en_ALU_Op    : 4-bit opcode encoding (1010-1111 reserved)
//   en_ALU_State : control FSM states
//   FLAG_*       : bit positions of N, Z, C, V inside a 4-bit flag vector
package arm_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_ORR  = 4'b0011,
        OP_EOR  = 4'b0100,
        OP_BIC  = 4'b0101,
        OP_ADC  = 4'b0110,
        OP_SBC  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_MULH = 4'b1001
    } en_ALU_Op;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } en_ALU_State;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_alu_seq_multiplier.sv
// Iterative shift-add unsigned multiplier.
//   i_CLK, i_RST : clock, asynchronous active-high reset
//   start        : load A/B and begin; ignored while an operation is in flight
//   a, b         : unsigned operands
//   done         : high during the cycle whose closing edge retires the last digit
//   product      : full 2*BusWidth product, valid while done is high
// BitsPerCycle multiplier bits are retired per edge, so an operation takes
// BusWidth/BitsPerCycle edges after the start edge. done and product are
// combinational so the parent can register the result on that last edge.
module arm_alu_seq_multiplier #(
    parameter int BusWidth     = 32,
    parameter int BitsPerCycle = 1
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    start,
    input  logic [BusWidth-1:0]     a,
    input  logic [BusWidth-1:0]     b,
    output logic                    done,
    output logic [2*BusWidth-1:0]   product
);

    localparam int ITER  = BusWidth / BitsPerCycle;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    logic                  busy;
    logic [CNT_W-1:0]      count;
    logic [2*BusWidth-1:0] mcand_sh;   // multiplicand, pre-shifted to the current digit weight
    logic [BusWidth-1:0]   mplier;     // remaining multiplier digits, low digit first
    logic [2*BusWidth-1:0] acc;
    logic [2*BusWidth-1:0] acc_next;
    logic [BitsPerCycle-1:0] digit;

    assign digit    = mplier[BitsPerCycle-1:0];
    assign acc_next = acc + mcand_sh * (2*BusWidth)'(digit);
    assign done     = busy && (count == LAST);
    assign product  = acc_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            busy     <= 1'b0;
            count    <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            acc      <= '0;
        end else if (start && !busy) begin
            busy     <= 1'b1;
            count    <= '0;
            mcand_sh <= {{BusWidth{1'b0}}, a};
            mplier   <= b;
            acc      <= '0;
        end else if (busy) begin
            acc      <= acc_next;
            mcand_sh <= mcand_sh << BitsPerCycle;
            mplier   <= mplier >> BitsPerCycle;
            count    <= count + 1'b1;
            if (count == LAST)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/arm_pipelined_alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshake and ARM NZCV flags.
//   i_CLK, i_RST  : clock, asynchronous active-high reset
//   i_Valid       : request; accepted when i_Valid && o_Ready on a rising edge
//   o_Ready       : block can accept a request this cycle
//   i_In_A/i_In_B : operands
//   i_ALU_Control : opcode (en_ALU_Op); 1010-1111 reserved
//   i_Flags       : current {N,Z,C,V}; C is ADC/SBC carry-in and pass-through source
//   o_Valid       : result registered and held until i_Ready
//   i_Ready       : consumer takes the result
//   o_Out         : result
//   o_Flags       : {N,Z,C,V} from the operation
//   o_Illegal     : opcode was reserved
// Single-cycle ops register their result on the accept edge; MUL/MULH run
// the sequential multiplier and complete BusWidth/BitsPerCycle edges later.
module arm_pipelined_alu_mc
    import arm_alu_pkg::*;
#(
    parameter int BusWidth     = 32,
    parameter int BitsPerCycle = 1
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_Valid,
    output logic                o_Ready,
    input  logic [BusWidth-1:0] i_In_A,
    input  logic [BusWidth-1:0] i_In_B,
    input  logic [3:0]          i_ALU_Control,
    input  logic [3:0]          i_Flags,
    output logic                o_Valid,
    input  logic                i_Ready,
    output logic [BusWidth-1:0] o_Out,
    output logic [3:0]          o_Flags,
    output logic                o_Illegal
);

    localparam int MSB = BusWidth - 1;

    en_ALU_State           state;
    logic                  mulh_q;     // captured: high half wanted
    logic [1:0]            cv_q;       // captured {C,V} for multiply pass-through
    logic                  accept;
    logic                  is_mul;

    logic [BusWidth-1:0]   b_op;
    logic                  cin;
    logic [BusWidth:0]     sum;
    logic [BusWidth-1:0]   alu_res;
    logic [3:0]            alu_flags;
    logic                  alu_illegal;

    logic                  mul_done;
    logic [2*BusWidth-1:0] mul_product;
    logic [BusWidth-1:0]   mul_res;

    assign o_Ready = (state == IDLE) || ((state == DONE) && i_Ready);
    assign o_Valid = (state == DONE);
    assign accept  = i_Valid && o_Ready;
    assign is_mul  = (i_ALU_Control == OP_MUL) || (i_ALU_Control == OP_MULH);

    // Single-cycle datapath. Subtraction is A + ~B + cin so C=1 means no borrow,
    // and one overflow rule (same-sign addends, different-sign sum) covers all
    // four arithmetic ops because b_op is already inverted for SUB/SBC.
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can infer a latch.
    always_comb begin
        b_op        = i_In_B;
        cin         = 1'b0;
        alu_res     = '0;
        alu_flags   = i_Flags;
        alu_illegal = 1'b0;

        case (i_ALU_Control)
            OP_SUB: begin b_op = ~i_In_B; cin = 1'b1;             end
            OP_ADC: begin                 cin = i_Flags[FLAG_C];  end
            OP_SBC: begin b_op = ~i_In_B; cin = i_Flags[FLAG_C];  end
            default: ;
        endcase

        sum = {1'b0, i_In_A} + {1'b0, b_op} + {{BusWidth{1'b0}}, cin};

        case (i_ALU_Control)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                alu_res           = sum[MSB:0];
                alu_flags[FLAG_C] = sum[BusWidth];
                alu_flags[FLAG_V] = (i_In_A[MSB] == b_op[MSB]) && (sum[MSB] != i_In_A[MSB]);
            end
            OP_AND:  alu_res = i_In_A & i_In_B;
            OP_ORR:  alu_res = i_In_A | i_In_B;
            OP_EOR:  alu_res = i_In_A ^ i_In_B;
            OP_BIC:  alu_res = i_In_A & ~i_In_B;
            default: alu_illegal = 1'b1;  // reserved: result 0, flags pass through
        endcase

        if (!alu_illegal) begin
            alu_flags[FLAG_N] = alu_res[MSB];
            alu_flags[FLAG_Z] = (alu_res == '0);
        end
    end

    assign mul_res = mulh_q ? mul_product[2*BusWidth-1:BusWidth] : mul_product[MSB:0];

    arm_alu_seq_multiplier #(
        .BusWidth     (BusWidth),
        .BitsPerCycle (BitsPerCycle)
    ) u_mult (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .start   (accept && is_mul),
        .a       (i_In_A),
        .b       (i_In_B),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state     <= IDLE;
            o_Out     <= '0;
            o_Flags   <= '0;
            o_Illegal <= 1'b0;
            mulh_q    <= 1'b0;
            cv_q      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state  <= MUL;
                            mulh_q <= (i_ALU_Control == OP_MULH);
                            cv_q   <= {i_Flags[FLAG_C], i_Flags[FLAG_V]};
                        end else begin
                            state     <= DONE;
                            o_Out     <= alu_res;
                            o_Flags   <= alu_flags;
                            o_Illegal <= alu_illegal;
                        end
                    end else if (state == DONE && i_Ready) begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state     <= DONE;
                        o_Out     <= mul_res;
                        o_Flags   <= {mul_res[MSB], (mul_res == '0), cv_q};
                        o_Illegal <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
